aes_stream_shell: RTL and testbench
===================================

AES_STREAM_SHELL -- requirements
Module: aes_stream_shell

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, FIFO word width; constraint DATA_WIDTH >= 16*LANES+16.
REQ-002 SHALL have parameter LANES, default 1, key/data byte pairs per input word; LANES in {1,2,4,8,16}.
REQ-003 SHALL have parameter BLOCK_BYTES, default 16, cipher block size; a multiple of LANES.
REQ-004 SHALL have port clock, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports data_empty input 1, data_rd output 1, data_din input DATA_WIDTH; first-word-fall-through input FIFO; data_rd pops.
REQ-007 SHALL have ports data_full input 1, data_wr output 1, data_dout output DATA_WIDTH; output FIFO write side.
REQ-008 SHALL have ports core_key output 8*BLOCK_BYTES, core_din output 8*BLOCK_BYTES, core_start output 1; cipher core request.
REQ-009 SHALL have ports core_done input 1, core_dout input 8*BLOCK_BYTES; cipher core one-cycle completion pulse and result.
REQ-010 SHALL have ports err output 1 (sticky framing error) and blk_count output 16 (completed blocks).

Function
REQ-011 SHALL use input word fields: data byte(s) din[8*LANES-1:0], key byte(s) din[16*LANES-1:8*LANES], flag din[DATA_WIDTH-1:DATA_WIDTH-16]; other bits ignored.
REQ-012 SHALL define NW = BLOCK_BYTES/LANES words per block; word k fills bits [8*BLOCK_BYTES-1-8*LANES*k -: 8*LANES] of the data and key shadow registers (MSB first).
REQ-013 SHALL implement states LOAD, START, WAIT, DRAIN; reset state LOAD.
REQ-014 LOAD: data_rd = !data_empty (combinational); each pop captures one word and increments word counter wc (0..NW-1).
REQ-015 Flag rules: words 0..NW-2 SHALL carry flag 16'h0000; word NW-1 SHALL carry 16'h1111 (load new key) or 16'h2222 (reuse held key).
REQ-016 On word NW-1 with 16'h1111: key shadow (including current word) copied to core_key; with 16'h2222: core_key unchanged, key fields of the block ignored; then wc<=0, go to START.
REQ-017 Flag violation (nonzero flag before word NW-1, or any other value on word NW-1): err<=1 (sticky until reset), block discarded, wc<=0, remain LOAD; the offending word is consumed.
REQ-018 START: core_start=1 for exactly one cycle, core_din/core_key stable from START until WAIT exits; next state WAIT.
REQ-019 WAIT: on core_done, capture core_dout into output register, go to DRAIN; core_done in any other state SHALL be ignored.
REQ-020 DRAIN: data_wr = !data_full; each write emits next 8*LANES result bits MSB first in data_dout[8*LANES-1:0], upper flag 16'h1111 on word NW-1 else 16'h0000, remaining bits 0.
REQ-021 After final DRAIN write: blk_count increments (wraps 16'hFFFF->0), go to LOAD; data_rd SHALL be 0 outside LOAD, data_wr 0 outside DRAIN.
REQ-022 Latency: final input word popped at cycle t -> core_start at t+1; core_done at cycle u -> first data_wr at u+1 if data_full=0; data_full stalls without loss or duplication.
REQ-023 data_empty or data_full asserted mid-block SHALL stall only, preserving wc and partial shadow contents.

Reset
REQ-024 Reset SHALL force, in the same cycle it is sampled: state LOAD, wc 0, data_rd 0, data_wr 0, core_start 0, err 0, blk_count 0, core_key/core_din/data_dout/shadows all zero.
REQ-025 Reset asserted mid-LOAD, WAIT or DRAIN SHALL abandon the block; a core_done arriving after reset SHALL be ignored.
REQ-026 Key reuse (16'h2222) before any 16'h1111 block SHALL use the all-zero key.

Verification
REQ-027 LANES=1: 16 words key 000102..0f / pt 00112233..ff, last flag 1111, AES-128 core model -> core_start 1 cycle after 16th pop; 16 output bytes 69c4e0d86a7b0430d8cdb78070b4c55a, last flag 1111, blk_count=1.
REQ-028 Second block with flag 2222, garbage key bytes, same pt -> identical ciphertext, blk_count=2.
REQ-029 Flag 1111 on word 5 -> err=1, no core_start; subsequent valid 16-word block completes normally.
REQ-030 data_full toggled every other cycle during DRAIN and data_empty randomly during LOAD -> output byte sequence unchanged, exactly 16 writes.
REQ-031 Reset pulsed during WAIT, then core_done pulsed -> no data_wr, state LOAD, all outputs zero.
REQ-032 LANES=4, DATA_WIDTH=80: 4 words per block with FIPS-197 vector -> 4 output words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.

Source files
------------

// File: rtl/aes_stream_shell.sv
// Streams key/plaintext words from an input FIFO into a block cipher core and
// drains the resulting ciphertext back out, lane by lane, to an output FIFO.
module aes_stream_shell #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LANES       = 1,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     data_empty,
  output logic                     data_rd,
  input  logic [DATA_WIDTH-1:0]    data_din,
  input  logic                     data_full,
  output logic                     data_wr,
  output logic [DATA_WIDTH-1:0]    data_dout,
  output logic [8*BLOCK_BYTES-1:0] core_key,
  output logic [8*BLOCK_BYTES-1:0] core_din,
  output logic                     core_start,
  input  logic                     core_done,
  input  logic [8*BLOCK_BYTES-1:0] core_dout,
  output logic                     err,
  output logic [15:0]              blk_count
);

  localparam int unsigned DW = 8 * LANES;
  localparam int unsigned SW = 8 * BLOCK_BYTES;
  localparam int unsigned NW = BLOCK_BYTES / LANES;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  localparam logic [15:0] FLAG_NONE    = 16'h0000;
  localparam logic [15:0] FLAG_NEW_KEY = 16'h1111;
  localparam logic [15:0] FLAG_OLD_KEY = 16'h2222;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] wc;
  logic [CW-1:0] dc;
  logic [SW-1:0] data_sh;
  logic [SW-1:0] key_sh;
  logic [SW-1:0] data_nxt;
  logic [SW-1:0] key_nxt;
  logic [SW-1:0] res;
  logic [15:0]   flag;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_key;
  logic          wc_last;
  logic          dc_last;
  logic          flag_final_ok;

  assign flag          = data_din[DATA_WIDTH-1 -: 16];
  assign in_data       = data_din[DW-1:0];
  assign in_key        = data_din[2*DW-1:DW];
  assign wc_last       = (wc == LAST);
  assign dc_last       = (dc == LAST);
  assign flag_final_ok = (flag == FLAG_NEW_KEY) || (flag == FLAG_OLD_KEY);

  // Words arrive MSB first, so shifting left and inserting at the bottom
  // leaves word 0 in the top slot once the block is complete.
  assign data_nxt = (data_sh << DW) | SW'(in_data);
  assign key_nxt  = (key_sh << DW) | SW'(in_key);

  generate
    if (DATA_WIDTH > 2 * DW + 16) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^data_din[DATA_WIDTH-17:2*DW];
    end
  endgenerate

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and FIFO/core handshakes; everything is held low during reset.
  always_comb begin
    state_nxt  = state;
    data_rd    = 1'b0;
    data_wr    = 1'b0;
    core_start = 1'b0;
    data_dout  = '0;
    if (!reset) begin
      case (state)
        LOAD: begin
          data_rd = !data_empty;
          if (!data_empty && wc_last && flag_final_ok) begin
            state_nxt = START;
          end
        end
        START: begin
          core_start = 1'b1;
          state_nxt  = WAIT;
        end
        WAIT: begin
          if (core_done) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          data_wr                       = !data_full;
          data_dout[DW-1:0]             = res[SW-1 -: DW];
          data_dout[DATA_WIDTH-1 -: 16] = dc_last ? FLAG_NEW_KEY : FLAG_NONE;
          if (!data_full && dc_last) begin
            state_nxt = LOAD;
          end
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  // Shadow loading, core request registers, result drain and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      wc        <= '0;
      dc        <= '0;
      data_sh   <= '0;
      key_sh    <= '0;
      res       <= '0;
      core_key  <= '0;
      core_din  <= '0;
      err       <= 1'b0;
      blk_count <= '0;
    end else begin
      if (data_rd) begin
        if (!wc_last) begin
          if (flag != FLAG_NONE) begin
            err <= 1'b1;
            wc  <= '0;
          end else begin
            data_sh <= data_nxt;
            key_sh  <= key_nxt;
            wc      <= wc + CW'(1);
          end
        end else begin
          wc      <= '0;
          data_sh <= data_nxt;
          key_sh  <= key_nxt;
          if (flag == FLAG_NEW_KEY) begin
            core_din <= data_nxt;
            core_key <= key_nxt;
          end else if (flag == FLAG_OLD_KEY) begin
            core_din <= data_nxt;
          end else begin
            err <= 1'b1;
          end
        end
      end

      if (state == WAIT && core_done) begin
        res <= core_dout;
        dc  <= '0;
      end

      if (data_wr) begin
        res <= res << DW;
        if (dc_last) begin
          dc        <= '0;
          blk_count <= blk_count + 16'd1;
        end else begin
          dc <= dc + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_shell.sv
// Directed bench for aes_stream_shell: one-lane and four-lane instances driven
// by FIFO and cipher-core models, checking FIPS-197 AES-128 results.
module tb_aes_stream_shell;

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] GARB = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         d1_empty, d1_rd, d1_full, d1_wr, d1_start, d1_done, d1_err;
  logic [31:0]  d1_din, d1_dout;
  logic [127:0] d1_key, d1_cdin, d1_cdout;
  logic [15:0]  d1_cnt;

  logic         d4_empty, d4_rd, d4_full, d4_wr, d4_start, d4_done, d4_err;
  logic [79:0]  d4_din, d4_dout;
  logic [127:0] d4_key, d4_cdin, d4_cdout;
  logic [15:0]  d4_cnt;

  aes_stream_shell #(.DATA_WIDTH(32), .LANES(1), .BLOCK_BYTES(16)) dut (
    .clock(clock), .reset(reset),
    .data_empty(d1_empty), .data_rd(d1_rd), .data_din(d1_din),
    .data_full(d1_full), .data_wr(d1_wr), .data_dout(d1_dout),
    .core_key(d1_key), .core_din(d1_cdin), .core_start(d1_start),
    .core_done(d1_done), .core_dout(d1_cdout),
    .err(d1_err), .blk_count(d1_cnt)
  );

  aes_stream_shell #(.DATA_WIDTH(80), .LANES(4), .BLOCK_BYTES(16)) dut4 (
    .clock(clock), .reset(reset),
    .data_empty(d4_empty), .data_rd(d4_rd), .data_din(d4_din),
    .data_full(d4_full), .data_wr(d4_wr), .data_dout(d4_dout),
    .core_key(d4_key), .core_din(d4_cdin), .core_start(d4_start),
    .core_done(d4_done), .core_dout(d4_cdout),
    .err(d4_err), .blk_count(d4_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sel = 1'b0;
  bit rand_empty = 1'b0;
  bit full_toggle = 1'b0;

  logic [79:0]  qi[$];
  logic [79:0]  qo[$];
  logic [127:0] model_out;
  int npops, nstarts, nwr, ndone;
  int last_pop, start_cyc, done_cyc, first_wr, done_cnt;

  // Cipher core stand-in: knows the FIPS-197 vector, scrambles anything else.
  function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] p);
    if (k == KEY && p == PT) return CT;
    return p ^ k ^ MASK;
  endfunction

  function automatic logic [79:0] exp1(input int j, input logic [127:0] blk);
    logic [15:0] f;
    f = (j == 15) ? 16'h1111 : 16'h0000;
    return {48'h0, f, 8'h00, blk[127-8*j -: 8]};
  endfunction

  function automatic logic [79:0] exp4(input int j, input logic [127:0] blk);
    logic [15:0] f;
    f = (j == 3) ? 16'h1111 : 16'h0000;
    return {f, 32'h0, blk[127-32*j -: 32]};
  endfunction

  task automatic clear_stats();
    qo.delete();
    npops = 0; nstarts = 0; nwr = 0; ndone = 0;
    last_pop = -100; start_cyc = -200; done_cyc = -300; first_wr = -400;
    done_cnt = 0;
  endtask

  task automatic push_block1(input logic [15:0] last_flag, input logic [127:0] key,
                             input logic [127:0] pt);
    for (int k = 0; k < 16; k++) begin
      qi.push_back({48'h0, (k == 15) ? last_flag : 16'h0000, key[127-8*k -: 8], pt[127-8*k -: 8]});
    end
  endtask

  // One clock: drive models at the falling edge, record handshakes, step the edge.
  task automatic tick();
    logic rd, em, wr, st, dn;
    logic [79:0]  dout;
    logic [127:0] k, p;
    if (!sel) begin
      d1_empty = (qi.size() == 0) || (rand_empty && $urandom_range(0, 1) == 1);
      d1_din   = (qi.size() != 0) ? qi[0][31:0] : 32'h0;
      d1_full  = full_toggle && (cyc % 2 == 1);
      d1_done  = (done_cnt == 1);
      d1_cdout = d1_done ? model_out : 128'h0;
      d4_empty = 1'b1; d4_din = '0; d4_full = 1'b0; d4_done = 1'b0; d4_cdout = '0;
    end else begin
      d4_empty = (qi.size() == 0) || (rand_empty && $urandom_range(0, 1) == 1);
      d4_din   = (qi.size() != 0) ? qi[0] : 80'h0;
      d4_full  = full_toggle && (cyc % 2 == 1);
      d4_done  = (done_cnt == 1);
      d4_cdout = d4_done ? model_out : 128'h0;
      d1_empty = 1'b1; d1_din = '0; d1_full = 1'b0; d1_done = 1'b0; d1_cdout = '0;
    end
    #1;
    rd   = sel ? d4_rd : d1_rd;
    em   = sel ? d4_empty : d1_empty;
    wr   = sel ? d4_wr : d1_wr;
    st   = sel ? d4_start : d1_start;
    dn   = sel ? d4_done : d1_done;
    dout = sel ? d4_dout : {48'h0, d1_dout};
    k    = sel ? d4_key : d1_key;
    p    = sel ? d4_cdin : d1_cdin;
    if (rd && !em) begin
      qi.delete(0);
      npops++;
      last_pop = cyc;
    end
    if (dn) begin
      ndone++;
      done_cyc = cyc;
    end
    if (wr) begin
      if (nwr == 0) first_wr = cyc;
      nwr++;
      qo.push_back(dout);
    end
    if (st) begin
      nstarts++;
      start_cyc = cyc;
      model_out = model(k, p);
      done_cnt = LAT;
    end else if (done_cnt > 0) begin
      done_cnt--;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (qo.size() < n && b < budget) begin
      tick();
      b++;
    end
    ok = (qo.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d1_empty = 1'b0; d1_din = 32'h0000_0155; d1_full = 1'b0; d1_done = 1'b0; d1_cdout = '0;
    d4_empty = 1'b0; d4_din = '0; d4_full = 1'b0; d4_done = 1'b0; d4_cdout = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    checks++; if (d1_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", d1_rd); end
    checks++; if (d4_rd !== 1'b0) begin errors++; $display("FAIL reset_rd4: got %b expected 0", d4_rd); end
    checks++; if (d1_wr !== 1'b0 || d1_start !== 1'b0) begin errors++; $display("FAIL reset_wr_start: got %b%b expected 00", d1_wr, d1_start); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", d1_err); end
    checks++; if (d1_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", d1_cnt); end
    checks++; if (d1_key !== 128'h0 || d1_cdin !== 128'h0) begin errors++; $display("FAIL reset_core_regs: got %h %h expected zero", d1_key, d1_cdin); end
    checks++; if (d1_dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", d1_dout); end
    reset = 1'b0;
    d1_empty = 1'b1;
    d4_empty = 1'b1;
    #1;
    checks++; if (d1_rd !== 1'b0) begin errors++; $display("FAIL idle_rd: got %b expected 0", d1_rd); end
    d1_empty = 1'b0;
    #1;
    checks++; if (d1_rd !== 1'b1) begin errors++; $display("FAIL load_rd_comb: got %b expected 1", d1_rd); end
    d1_empty = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_fips_block();
    bit ok;
    sel = 1'b0;
    clear_stats();
    push_block1(16'h1111, KEY, PT);
    run_until(16, 200, ok);
    repeat (3) tick();
    checks++; if (!ok) begin errors++; $display("FAIL fips_timeout: got %0d words expected 16", qo.size()); end
    checks++; if (nstarts != 1) begin errors++; $display("FAIL fips_starts: got %0d expected 1", nstarts); end
    checks++; if (start_cyc - last_pop != 1) begin errors++; $display("FAIL fips_start_latency: got %0d expected 1", start_cyc - last_pop); end
    checks++; if (first_wr - done_cyc != 1) begin errors++; $display("FAIL fips_wr_latency: got %0d expected 1", first_wr - done_cyc); end
    checks++; if (nwr != 16) begin errors++; $display("FAIL fips_writes: got %0d expected 16", nwr); end
    for (int j = 0; j < 16; j++) begin
      checks++; if (qo[j] !== exp1(j, CT)) begin errors++; $display("FAIL fips_word%0d: got %h expected %h", j, qo[j], exp1(j, CT)); end
    end
    checks++; if (d1_cnt !== 16'd1) begin errors++; $display("FAIL fips_cnt: got %0d expected 1", d1_cnt); end
    checks++; if (d1_key !== KEY) begin errors++; $display("FAIL fips_key: got %h expected %h", d1_key, KEY); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL fips_err: got %b expected 0", d1_err); end
  endtask

  task automatic test_key_reuse();
    bit ok;
    clear_stats();
    push_block1(16'h2222, GARB, PT);
    run_until(16, 200, ok);
    repeat (3) tick();
    checks++; if (!ok || nstarts != 1) begin errors++; $display("FAIL reuse_run: got %0d words %0d starts expected 16 1", qo.size(), nstarts); end
    checks++; if (d1_key !== KEY) begin errors++; $display("FAIL reuse_key_held: got %h expected %h", d1_key, KEY); end
    checks++; if (d1_cdin !== PT) begin errors++; $display("FAIL reuse_din: got %h expected %h", d1_cdin, PT); end
    for (int j = 0; j < 16; j++) begin
      checks++; if (qo[j] !== exp1(j, CT)) begin errors++; $display("FAIL reuse_word%0d: got %h expected %h", j, qo[j], exp1(j, CT)); end
    end
    checks++; if (d1_cnt !== 16'd2) begin errors++; $display("FAIL reuse_cnt: got %0d expected 2", d1_cnt); end
  endtask

  task automatic test_flag_error();
    bit ok;
    clear_stats();
    for (int k = 0; k < 6; k++) begin
      qi.push_back({48'h0, (k == 5) ? 16'h1111 : 16'h0000, KEY[127-8*k -: 8], PT[127-8*k -: 8]});
    end
    repeat (12) tick();
    checks++; if (qi.size() != 0) begin errors++; $display("FAIL flagerr_consumed: got %0d left expected 0", qi.size()); end
    checks++; if (d1_err !== 1'b1) begin errors++; $display("FAIL flagerr_err: got %b expected 1", d1_err); end
    checks++; if (nstarts != 0 || nwr != 0) begin errors++; $display("FAIL flagerr_no_start: got %0d starts %0d writes expected 0 0", nstarts, nwr); end
    push_block1(16'h1111, KEY, PT);
    run_until(16, 200, ok);
    repeat (3) tick();
    checks++; if (!ok || nstarts != 1) begin errors++; $display("FAIL flagerr_recover: got %0d words %0d starts expected 16 1", qo.size(), nstarts); end
    for (int j = 0; j < 16; j++) begin
      checks++; if (qo[j] !== exp1(j, CT)) begin errors++; $display("FAIL flagerr_word%0d: got %h expected %h", j, qo[j], exp1(j, CT)); end
    end
    checks++; if (d1_cnt !== 16'd3) begin errors++; $display("FAIL flagerr_cnt: got %0d expected 3", d1_cnt); end
    checks++; if (d1_err !== 1'b1) begin errors++; $display("FAIL flagerr_sticky: got %b expected 1", d1_err); end
  endtask

  task automatic test_stall();
    bit ok;
    clear_stats();
    rand_empty = 1'b1;
    full_toggle = 1'b1;
    push_block1(16'h1111, KEY, PT);
    run_until(16, 400, ok);
    repeat (6) tick();
    rand_empty = 1'b0;
    full_toggle = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d words expected 16", qo.size()); end
    checks++; if (nwr != 16 || nstarts != 1) begin errors++; $display("FAIL stall_counts: got %0d writes %0d starts expected 16 1", nwr, nstarts); end
    for (int j = 0; j < 16; j++) begin
      checks++; if (qo[j] !== exp1(j, CT)) begin errors++; $display("FAIL stall_word%0d: got %h expected %h", j, qo[j], exp1(j, CT)); end
    end
    checks++; if (d1_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d expected 4", d1_cnt); end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int b;
    clear_stats();
    push_block1(16'h1111, KEY, PT);
    b = 0;
    while (nstarts == 0 && b < 100) begin
      tick();
      b++;
    end
    checks++; if (nstarts != 1) begin errors++; $display("FAIL rstwait_start: got %0d expected 1", nstarts); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (d1_err !== 1'b0 || d1_cnt !== 16'h0) begin errors++; $display("FAIL rstwait_status: got %b %h expected 0 0000", d1_err, d1_cnt); end
    checks++; if (d1_key !== 128'h0 || d1_cdin !== 128'h0) begin errors++; $display("FAIL rstwait_core_regs: got %h %h expected zero", d1_key, d1_cdin); end
    repeat (8) tick();
    checks++; if (ndone != 1) begin errors++; $display("FAIL rstwait_done_seen: got %0d expected 1", ndone); end
    checks++; if (nwr != 0) begin errors++; $display("FAIL rstwait_no_write: got %0d expected 0", nwr); end
    checks++; if (d1_wr !== 1'b0 || d1_dout !== 32'h0 || d1_cnt !== 16'h0) begin errors++; $display("FAIL rstwait_idle: got %b %h %h expected 0 0 0", d1_wr, d1_dout, d1_cnt); end
    clear_stats();
    push_block1(16'h2222, GARB, PT);
    run_until(16, 200, ok);
    repeat (3) tick();
    checks++; if (!ok || nstarts != 1) begin errors++; $display("FAIL zerokey_run: got %0d words %0d starts expected 16 1", qo.size(), nstarts); end
    checks++; if (d1_key !== 128'h0) begin errors++; $display("FAIL zerokey_key: got %h expected 0", d1_key); end
    for (int j = 0; j < 16; j++) begin
      checks++; if (qo[j] !== exp1(j, PT ^ MASK)) begin errors++; $display("FAIL zerokey_word%0d: got %h expected %h", j, qo[j], exp1(j, PT ^ MASK)); end
    end
    checks++; if (d1_cnt !== 16'd1) begin errors++; $display("FAIL zerokey_cnt: got %0d expected 1", d1_cnt); end
  endtask

  task automatic test_lanes4();
    bit ok;
    sel = 1'b1;
    clear_stats();
    for (int k = 0; k < 4; k++) begin
      qi.push_back({(k == 3) ? 16'h1111 : 16'h0000, KEY[127-32*k -: 32], PT[127-32*k -: 32]});
    end
    run_until(4, 100, ok);
    repeat (3) tick();
    checks++; if (!ok || nstarts != 1 || nwr != 4) begin errors++; $display("FAIL l4_run: got %0d words %0d starts expected 4 1", qo.size(), nstarts); end
    checks++; if (start_cyc - last_pop != 1) begin errors++; $display("FAIL l4_start_latency: got %0d expected 1", start_cyc - last_pop); end
    checks++; if (first_wr - done_cyc != 1) begin errors++; $display("FAIL l4_wr_latency: got %0d expected 1", first_wr - done_cyc); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (qo[j] !== exp4(j, CT)) begin errors++; $display("FAIL l4_word%0d: got %h expected %h", j, qo[j], exp4(j, CT)); end
    end
    checks++; if (d4_cnt !== 16'd1 || d4_err !== 1'b0) begin errors++; $display("FAIL l4_status: got %0d %b expected 1 0", d4_cnt, d4_err); end
    checks++; if (d4_key !== KEY) begin errors++; $display("FAIL l4_key: got %h expected %h", d4_key, KEY); end
  endtask

  initial begin
    clear_stats();
    model_out = '0;
    test_reset();
    test_fips_block();
    test_key_reuse();
    test_flag_error();
    test_stall();
    test_reset_in_wait();
    test_lanes4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
